// File: rtl/serial_cmp_pkg.sv
// ----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared types and constants for the bit-serial compare sequencer.
//   state_t      : sequencer FSM states (IDLE, SHIFT, DONE)
//   cmp_result_t : one-hot {less, eq, greater} compare result
//   RES_*        : the three legal one-hot result encodings
// ----------------------------------------------------------------------------
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

    localparam logic [2:0] RES_LESS    = 3'b100;
    localparam logic [2:0] RES_EQ      = 3'b010;
    localparam logic [2:0] RES_GREATER = 3'b001;

endpackage

// File: rtl/serial_msb_cmp_core.sv
// ----------------------------------------------------------------------------
// serial_msb_cmp_core
// Most-significant-first bit-serial magnitude comparator. Bits of both
// operands arrive one pair per cycle. The first differing pair decides the
// outcome, and every later bit is ignored until the core is cleared.
//   clk       : clock
//   rst       : synchronous active-high reset
//   clr       : synchronous clear, starts a fresh comparison
//   bit_valid : a/b carry a bit pair this cycle
//   a, b      : current operand bits
//   less      : a < b so far (including the current bit)
//   eq        : a == b so far (including the current bit)
//   greater   : a > b so far (including the current bit)
// ----------------------------------------------------------------------------
module serial_msb_cmp_core
    import serial_cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_valid,
    input  logic a,
    input  logic b,
    output logic less,
    output logic eq,
    output logic greater
);

    logic r_decided;
    logic r_lessThan;

    // Decision state. The first differing bit pair latches the ordering,
    // and nothing but clr or rst releases it, because lower bits can no
    // longer change an MSB-first result.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_decided  <= 1'b0;
            r_lessThan <= 1'b0;
        end else if (bit_valid && !r_decided && (a != b)) begin
            r_decided  <= 1'b1;
            r_lessThan <= !a;
        end
    end

    // The outputs already reflect the bit on the inputs, so the sequencer
    // can capture a final result in the same cycle it feeds the last bit.
    always_comb begin
        eq      = !r_decided && (a == b);
        less    = r_decided ? r_lessThan  : (!a && b);
        greater = r_decided ? !r_lessThan : (a && !b);
    end

endmodule

// File: rtl/serial_compare_sequencer.sv
// ----------------------------------------------------------------------------
// serial_compare_sequencer
// Accepts a whole-word operand pair, clears the serial comparator core and
// feeds it both operands MSB first, one bit pair per cycle. It then holds
// the one-hot result until the consumer takes it.
// Parameters:
//   WIDTH      : operand width in bits (>= 1)
//   EARLY_EXIT : 1 = stop at the first differing bit, 0 = always shift WIDTH
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : operand pair valid         in_ready  : accepting (IDLE only)
//   in_a, in_b : unsigned operands
//   out_valid  : result valid (DONE only)   out_ready : consumer accepts
//   out_result : {less, eq, greater}
//   out_bits   : bit pairs fed to the core for this result (1..WIDTH)
// ----------------------------------------------------------------------------
module serial_compare_sequencer
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_result,
    output logic [CW-1:0]    out_bits
);

    state_t            r_state;
    state_t            w_nextState;
    logic [WIDTH-1:0]  r_shiftA;
    logic [WIDTH-1:0]  r_shiftB;
    logic [CW-1:0]     r_count;
    cmp_result_t       r_result;
    logic [CW-1:0]     r_bits;

    logic              w_accept;
    logic              w_bitValid;
    logic              w_lastBit;
    logic              w_finish;
    logic              w_less;
    logic              w_eq;
    logic              w_greater;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_bits   = r_bits;

    assign w_accept   = in_valid && in_ready;
    assign w_bitValid = (r_state == SHIFT);
    assign w_lastBit  = (r_count == CW'(WIDTH - 1));

    // Finishing is decided in the same cycle as the bit that settles it, so
    // the core outputs seen here already include that bit.
    assign w_finish   = w_bitValid && (w_lastBit || ((EARLY_EXIT != 0) && !w_eq));

    serial_msb_cmp_core u_core (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_accept),
        .bit_valid (w_bitValid),
        .a         (r_shiftA[WIDTH-1]),
        .b         (r_shiftB[WIDTH-1]),
        .less      (w_less),
        .eq        (w_eq),
        .greater   (w_greater)
    );

    // State register. Reset overrides everything, so a result that is in
    // flight or waiting in DONE is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE always returns through IDLE, so a new accept
    // can only happen in the cycle after the output handshake.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_nextState = SHIFT;
            SHIFT:   if (w_finish)  w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default:                w_nextState = IDLE;
        endcase
    end

    // Operand shifters, bit counter and result capture. The counter starts
    // at zero on accept, and the captured count is count+1 because the
    // current bit is being fed in the capture cycle. The counter can reach
    // WIDTH at most, which CW always holds, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shiftA <= '0;
            r_shiftB <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_bits   <= '0;
        end else begin
            if (w_accept) begin
                r_shiftA <= in_a;
                r_shiftB <= in_b;
                r_count  <= '0;
            end else if (w_bitValid) begin
                r_shiftA <= r_shiftA << 1;
                r_shiftB <= r_shiftB << 1;
                r_count  <= r_count + 1'b1;
            end
            if (w_finish) begin
                r_result <= '{less: w_less, eq: w_eq, greater: w_greater};
                r_bits   <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// ----------------------------------------------------------------------------
// tb_serial_compare_sequencer
// Drives two sequencer instances (WIDTH=8, EARLY_EXIT=0 and EARLY_EXIT=1)
// with directed operand pairs. A word-level model predicts handshake timing
// and results from plain integer compares. Literal expectations pin the
// headline cases.
// ----------------------------------------------------------------------------
module tb_serial_compare_sequencer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inValid   [2];
    logic [7:0] inA       [2];
    logic [7:0] inB       [2];
    logic       outReady  [2];
    logic       inReady   [2];
    logic       outValid  [2];
    logic [2:0] outResult [2];
    logic [3:0] outBits   [2];

    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    bit   armed  = 0;

    int         mPhase     [2];
    int         mLeft      [2];
    int         mAccepts   [2];
    int         mAcceptCyc [2];
    logic [2:0] mRes       [2];
    int         mBits      [2];
    bit         mFresh     [2];

    always #5 clk = ~clk;

    serial_compare_sequencer #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid[0]),
        .in_ready   (inReady[0]),
        .in_a       (inA[0]),
        .in_b       (inB[0]),
        .out_valid  (outValid[0]),
        .out_ready  (outReady[0]),
        .out_result (outResult[0]),
        .out_bits   (outBits[0])
    );

    serial_compare_sequencer #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid[1]),
        .in_ready   (inReady[1]),
        .in_a       (inA[1]),
        .in_b       (inB[1]),
        .out_valid  (outValid[1]),
        .out_ready  (outReady[1]),
        .out_result (outResult[1]),
        .out_bits   (outBits[1])
    );

    // Word-level ordering of two unsigned operands.
    function automatic logic [2:0] refResult(input logic [7:0] a, input logic [7:0] b);
        if (a < b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Bit pairs consumed: all of them, or up to the first differing bit.
    function automatic int refBits(input logic [7:0] a, input logic [7:0] b, input bit early);
        if (!early) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return W - i;
        end
        return W;
    endfunction

    task automatic check(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
    endtask

    // Model: 0 = waiting for an operand pair, 1 = busy for mLeft cycles,
    // 2 = result offered until the consumer takes it.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                armed = 1;
                for (int d = 0; d < 2; d++) begin
                    mPhase[d] = 0;
                    mFresh[d] = 1;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    case (mPhase[d])
                        0: if (inValid[d]) begin
                            mRes[d]       = refResult(inA[d], inB[d]);
                            mBits[d]      = refBits(inA[d], inB[d], d == 1);
                            mLeft[d]      = mBits[d];
                            mPhase[d]     = 1;
                            mFresh[d]     = 0;
                            mAccepts[d]   = mAccepts[d] + 1;
                            mAcceptCyc[d] = cyc;
                        end
                        1: begin
                            mLeft[d] = mLeft[d] - 1;
                            if (mLeft[d] == 0) mPhase[d] = 2;
                        end
                        default: if (outReady[d]) mPhase[d] = 0;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int d = 0; d < 2; d++) begin
                    check("in_ready",  d, {7'b0, inReady[d]},  {7'b0, mPhase[d] == 0});
                    check("out_valid", d, {7'b0, outValid[d]}, {7'b0, mPhase[d] == 2});
                    if (mPhase[d] == 2) begin
                        check("out_result", d, {5'b0, outResult[d]}, {5'b0, mRes[d]});
                        check("out_bits",   d, {4'b0, outBits[d]},   8'(mBits[d]));
                    end
                    if (mFresh[d]) begin
                        check("reset_result", d, {5'b0, outResult[d]}, 8'd0);
                        check("reset_bits",   d, {4'b0, outBits[d]},   8'd0);
                    end
                end
            end
        end
    end

    // Hold in_valid until the pair is accepted, then drop it.
    task automatic waitAccept(input int d);
        int prior = mAccepts[d];
        int n = 0;
        while (mAccepts[d] == prior && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (mAccepts[d] == prior) check("accept_timeout", d, 8'd0, 8'd1);
        inValid[d] = 1'b0;
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b);
        inA[d]     = a;
        inB[d]     = b;
        inValid[d] = 1'b1;
        waitAccept(d);
    endtask

    // Latency counts from the handshake cycle to the first out_valid cycle.
    task automatic checkOutput(input int d, input logic [2:0] expRes, input int expBits, input int expLat);
        int n = 0;
        while (outValid[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (outValid[d] !== 1'b1) begin
            check("out_timeout", d, 8'd0, 8'd1);
        end else begin
            check("lit_result",  d, {5'b0, outResult[d]}, {5'b0, expRes});
            check("lit_bits",    d, {4'b0, outBits[d]},   8'(expBits));
            check("lit_latency", d, 8'(cyc - mAcceptCyc[d] + 1), 8'(expLat));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            inValid[d]  = 1'b0;
            inA[d]      = 8'h00;
            inB[d]      = 8'h00;
            outReady[d] = 1'b1;
            mPhase[d]   = 0;
            mLeft[d]    = 0;
            mAccepts[d] = 0;
            mFresh[d]   = 1;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single compare, full shift.
        applyStimulus(0, 8'h64, 8'h62);
        checkOutput(0, 3'b001, 8, 9);

        // Back-to-back equal then less.
        applyStimulus(0, 8'hA5, 8'hA5);
        checkOutput(0, 3'b010, 8, 9);
        applyStimulus(0, 8'h26, 8'h86);
        checkOutput(0, 3'b100, 8, 9);

        // Early exit: MSB differs, then only the LSB differs.
        applyStimulus(1, 8'h12, 8'h92);
        checkOutput(1, 3'b100, 1, 2);
        applyStimulus(1, 8'h81, 8'h80);
        checkOutput(1, 3'b001, 8, 9);

        // Backpressure with a new pair waiting.
        outReady[0] = 1'b0;
        applyStimulus(0, 8'h33, 8'h33);
        checkOutput(0, 3'b010, 8, 9);
        inA[0]     = 8'h01;
        inB[0]     = 8'hFF;
        inValid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 0, {7'b0, inReady[0]},   8'd0);
            check("bp_result",   0, {5'b0, outResult[0]}, 8'd2);
            check("bp_bits",     0, {4'b0, outBits[0]},   8'd8);
        end
        outReady[0] = 1'b1;
        waitAccept(0);
        checkOutput(0, 3'b100, 8, 9);

        // Reset after three bits of a compare, then fresh compares.
        applyStimulus(0, 8'hF0, 8'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_in_ready",  0, {7'b0, inReady[0]},  8'd1);
        check("post_rst_out_valid", 0, {7'b0, outValid[0]}, 8'd0);
        applyStimulus(0, 8'h00, 8'h01);
        checkOutput(0, 3'b100, 8, 9);
        applyStimulus(1, 8'h00, 8'h01);
        checkOutput(1, 3'b100, 8, 9);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
